// File: rtl/grill_scheduler_pkg.sv
// Shared definitions for the grill game sequencer: doneness codes, flip scoring
// table and the state encodings of the game and per-slot sequencers.
package grill_scheduler_pkg;

  localparam logic [2:0] DN_NONE        = 3'd0;
  localparam logic [2:0] DN_RAW         = 3'd1;
  localparam logic [2:0] DN_RARE        = 3'd2;
  localparam logic [2:0] DN_MEDIUM_RARE = 3'd3;
  localparam logic [2:0] DN_MEDIUM      = 3'd4;
  localparam logic [2:0] DN_MEDIUM_WELL = 3'd5;
  localparam logic [2:0] DN_WELL_DONE   = 3'd6;
  localparam logic [2:0] DN_BURNT       = 3'd7;

  localparam int TIMER_W = 4;

  typedef enum logic [1:0] {
    GAME_IDLE,
    GAME_PLAY,
    GAME_OVER
  } game_state_e;

  typedef enum logic [1:0] {
    SLOT_WAIT,
    SLOT_READY,
    SLOT_SHOW,
    SLOT_COOK
  } slot_state_e;

  function automatic logic signed [3:0] flip_points(input logic [2:0] level);
    case (level)
      DN_RARE:        flip_points = 4'sd2;
      DN_MEDIUM_RARE: flip_points = 4'sd5;
      DN_MEDIUM:      flip_points = 4'sd5;
      DN_MEDIUM_WELL: flip_points = 4'sd3;
      DN_WELL_DONE:   flip_points = 4'sd1;
      DN_BURNT:       flip_points = -4'sd3;
      default:        flip_points = 4'sd0;
    endcase
  endfunction

endpackage

// File: rtl/grill_slot_seq.sv
// Per-slot appearance sequencer: waits a number of ticks, asks for a grant,
// holds show until the steak FSM comes alive, then waits for it to finish.
module grill_slot_seq
  import grill_scheduler_pkg::*;
#(
  parameter int INIT_TIMER = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       grant,
  input  logic       slot_busy,
  input  logic [2:0] rand_in,
  input  logic       load_init,
  input  logic       enable,
  output logic       ready,
  output logic       active,
  output logic       show
);

  slot_state_e        state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] rand_delay;

  assign rand_delay = {1'b0, rand_in} + TIMER_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= SLOT_WAIT;
      timer <= TIMER_W'(INIT_TIMER);
      show  <= 1'b0;
    end else if (load_init) begin
      state <= SLOT_WAIT;
      timer <= TIMER_W'(INIT_TIMER);
      show  <= 1'b0;
    end else begin
      case (state)
        SLOT_WAIT: begin
          if (tick) begin
            if (timer <= TIMER_W'(1)) begin
              state <= SLOT_READY;
              timer <= '0;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
        end
        SLOT_READY: begin
          if (grant && enable) begin
            state <= SLOT_SHOW;
            show  <= 1'b1;
          end
        end
        SLOT_SHOW: begin
          // Outside a round a pending appearance is withdrawn rather than held.
          if (!enable) begin
            state <= SLOT_WAIT;
            timer <= rand_delay;
            show  <= 1'b0;
          end else if (slot_busy) begin
            state <= SLOT_COOK;
            show  <= 1'b0;
          end
        end
        SLOT_COOK: begin
          if (!slot_busy) begin
            state <= SLOT_WAIT;
            timer <= rand_delay;
          end
        end
        default: begin
          state <= SLOT_WAIT;
          show  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = (state == SLOT_READY);
  assign active = (state == SLOT_SHOW) || (state == SLOT_COOK);

endmodule

// File: rtl/grill_scheduler.sv
// Game-level sequencer: round FSM and timer, round-robin appearance arbiter
// with a concurrency cap, and the saturating flip score accumulator.
module grill_scheduler
  import grill_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int GAME_TICKS = 60,
  parameter int MAX_SCORE  = 999
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   tick,
  input  logic                   start,
  input  logic [2:0]             rand_in,
  input  logic [NUM_SLOTS-1:0]   slot_busy,
  input  logic [NUM_SLOTS-1:0]   flip_evt,
  input  logic [3*NUM_SLOTS-1:0] flip_level,
  output logic [NUM_SLOTS-1:0]   show,
  output logic [9:0]             score,
  output logic [7:0]             time_left,
  output logic                   playing,
  output logic                   game_over
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  game_state_e          state;
  logic [PTR_W-1:0]     ptr;
  logic                 tick_q;
  logic                 in_play;
  logic                 load_init;
  logic [NUM_SLOTS-1:0] ready;
  logic [NUM_SLOTS-1:0] active;
  logic [NUM_SLOTS-1:0] grant;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [9:0]           score_next;
  int                   active_cnt;
  int                   idx;
  int                   delta;
  int                   sum;

  assign in_play   = (state == GAME_PLAY);
  assign load_init = start && !in_play;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    grill_slot_seq #(
      .INIT_TIMER (g + 1)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .grant     (grant[g]),
      .slot_busy (slot_busy[g]),
      .rand_in   (rand_in),
      .load_init (load_init),
      .enable    (in_play),
      .ready     (ready[g]),
      .active    (active[g]),
      .show      (show[g])
    );
  end

  // Grants are evaluated the cycle after a tick so slots readied by that tick compete.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant      = '0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    active_cnt = 0;
    idx        = 0;
    for (int i = 0; i < NUM_SLOTS; i++) active_cnt += int'(active[i]);
    if (tick_q && in_play && active_cnt < MAX_ACTIVE) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        idx = (int'(ptr) + k) % NUM_SLOTS;
        if (!grant_vld && ready[idx]) begin
          grant[idx] = 1'b1;
          grant_vld  = 1'b1;
          grant_idx  = PTR_W'(idx);
        end
      end
    end
    ptr_next = PTR_W'((int'(grant_idx) + 1) % NUM_SLOTS);
  end

  always_comb begin
    delta = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (flip_evt[i]) delta += int'(flip_points(flip_level[3*i +: 3]));
    end
    sum = int'(score) + delta;
    if (sum > MAX_SCORE)  score_next = 10'(MAX_SCORE);
    else if (sum < 0)     score_next = '0;
    else                  score_next = 10'(sum);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= GAME_IDLE;
      ptr       <= '0;
      tick_q    <= 1'b0;
      score     <= '0;
      time_left <= 8'(GAME_TICKS);
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      tick_q <= tick;
      case (state)
        GAME_PLAY: begin
          score <= score_next;
          if (grant_vld) ptr <= ptr_next;
          if (tick) begin
            if (time_left == 8'd1) begin
              time_left <= '0;
              state     <= GAME_OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              time_left <= time_left - 8'd1;
            end
          end
        end
        GAME_IDLE, GAME_OVER: begin
          if (start) begin
            state     <= GAME_PLAY;
            ptr       <= '0;
            score     <= '0;
            time_left <= 8'(GAME_TICKS);
            playing   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= GAME_IDLE;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grill_scheduler.sv
// Self-checking bench for grill_scheduler: directed scenarios followed by
// randomized play, all compared against a behavioural model of the game rules.
module tb_grill_scheduler;

  localparam int NS     = 4;
  localparam int MAXACT = 2;
  localparam int GT     = 60;
  localparam int MAXSC  = 999;

  localparam int ST_WAIT  = 0;
  localparam int ST_READY = 1;
  localparam int ST_SHOW  = 2;
  localparam int ST_COOK  = 3;
  localparam int G_IDLE   = 0;
  localparam int G_PLAY   = 1;
  localparam int G_OVER   = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            tick;
  logic            start;
  logic [2:0]      rand_in;
  logic [NS-1:0]   slot_busy;
  logic [NS-1:0]   flip_evt;
  logic [3*NS-1:0] flip_level;
  logic [NS-1:0]   show;
  logic [9:0]      score;
  logic [7:0]      time_left;
  logic            playing;
  logic            game_over;

  int n_checks = 0;
  int n_fail   = 0;

  int pts_tab[8] = '{0, 0, 2, 5, 5, 3, 1, -3};
  int m_game, m_time, m_score, m_ptr;
  bit m_tick_prev;
  int m_st[NS];
  int m_tmr[NS];

  grill_scheduler #(
    .NUM_SLOTS  (NS),
    .MAX_ACTIVE (MAXACT),
    .GAME_TICKS (GT),
    .MAX_SCORE  (MAXSC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tick       (tick),
    .start      (start),
    .rand_in    (rand_in),
    .slot_busy  (slot_busy),
    .flip_evt   (flip_evt),
    .flip_level (flip_level),
    .show       (show),
    .score      (score),
    .time_left  (time_left),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_show();
    logic [NS-1:0] s = '0;
    for (int i = 0; i < NS; i++) s[i] = (m_st[i] == ST_SHOW);
    return s;
  endfunction

  // Applies the game rules to the inputs seen at one clock edge.
  task automatic model_update();
    int  g, act, j, sum, rnd_delay;
    bit  play, start_ok;
    if (!resetn) begin
      m_game = G_IDLE; m_time = GT; m_score = 0; m_ptr = 0; m_tick_prev = 0;
      for (int i = 0; i < NS; i++) begin m_st[i] = ST_WAIT; m_tmr[i] = i + 1; end
      return;
    end
    play      = (m_game == G_PLAY);
    start_ok  = start && !play;
    rnd_delay = int'(rand_in) + 1;
    act = 0;
    for (int i = 0; i < NS; i++) if (m_st[i] == ST_SHOW || m_st[i] == ST_COOK) act++;
    g = -1;
    if (m_tick_prev && play && act < MAXACT) begin
      for (int k = 0; k < NS; k++) begin
        j = (m_ptr + k) % NS;
        if (g < 0 && m_st[j] == ST_READY) g = j;
      end
    end
    if (start_ok) begin
      m_game = G_PLAY; m_time = GT; m_score = 0; m_ptr = 0;
    end else if (play) begin
      sum = m_score;
      for (int i = 0; i < NS; i++) if (flip_evt[i]) sum += pts_tab[flip_level[3*i +: 3]];
      m_score = (sum > MAXSC) ? MAXSC : (sum < 0 ? 0 : sum);
      if (g >= 0) m_ptr = (g + 1) % NS;
      if (tick) begin
        if (m_time == 1) begin m_time = 0; m_game = G_OVER; end
        else m_time--;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (start_ok) begin
        m_st[i] = ST_WAIT; m_tmr[i] = i + 1;
      end else begin
        case (m_st[i])
          ST_WAIT:  if (tick) begin
                      if (m_tmr[i] == 1) m_st[i] = ST_READY;
                      else m_tmr[i]--;
                    end
          ST_READY: if (i == g) m_st[i] = ST_SHOW;
          ST_SHOW:  if (!play) begin m_st[i] = ST_WAIT; m_tmr[i] = rnd_delay; end
                    else if (slot_busy[i]) m_st[i] = ST_COOK;
          default:  if (!slot_busy[i]) begin m_st[i] = ST_WAIT; m_tmr[i] = rnd_delay; end
        endcase
      end
    end
    m_tick_prev = tick;
  endtask

  task automatic check_all();
    check("show", 32'(show), 32'(model_show()));
    check("score", 32'(score), 32'(m_score));
    check("time_left", 32'(time_left), 32'(m_time));
    check("playing", 32'(playing), 32'(m_game == G_PLAY));
    check("game_over", 32'(game_over), 32'(m_game == G_OVER));
  endtask

  // One clock: inputs held across the edge, model advanced, outputs checked at negedge.
  task automatic step();
    rand_in = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    tick     = 1'b0;
    start    = 1'b0;
    flip_evt = '0;
  endtask

  task automatic set_flip(input int slot, input int code);
    flip_evt[slot]            = 1'b1;
    flip_level[3*slot +: 3]   = 3'(code);
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; start = 1'b0; rand_in = '0;
    slot_busy = '0; flip_evt = '0; flip_level = '0;
    step(); step();
    check("reset_score", 32'(score), 32'd0);
    check("reset_time", 32'(time_left), 32'(GT));
    resetn = 1'b1;

    // First appearance and handshake
    start = 1'b1; step();
    tick = 1'b1; step();
    step();
    check("first_show", 32'(show), 32'b0001);
    slot_busy[0] = 1'b1; step();
    check("show_drop_on_busy", 32'(show), 32'b0000);

    // Concurrency cap and round-robin pointer
    tick = 1'b1; step(); step();
    check("second_show", 32'(show), 32'b0010);
    slot_busy[1] = 1'b1; step();
    tick = 1'b1; step(); step();
    check("cap_blocks_grant", 32'(show), 32'b0000);
    slot_busy[0] = 1'b0; step();
    tick = 1'b1; step(); step();
    check("rr_grants_slot2", 32'(show), 32'b0100);
    slot_busy[2] = 1'b1; step();
    slot_busy = '0; step();

    // Scoring: simultaneous flips, floor and ceiling clamps
    set_flip(0, 3); set_flip(1, 7); step();
    check("dual_flip", 32'(score), 32'd2);
    set_flip(0, 7); step();
    check("clamp_floor_a", 32'(score), 32'd0);
    set_flip(0, 6); step();
    check("score_one", 32'(score), 32'd1);
    set_flip(0, 7); step();
    check("clamp_floor_b", 32'(score), 32'd0);
    for (int k = 0; k < 49; k++) begin
      for (int i = 0; i < NS; i++) set_flip(i, 3);
      step();
    end
    set_flip(0, 3); set_flip(1, 3); set_flip(2, 3); set_flip(3, 5); step();
    check("score_998", 32'(score), 32'd998);
    set_flip(2, 4); step();
    check("clamp_ceiling", 32'(score), 32'd999);

    // Run out the round; a burnt flip lands on the final tick
    for (int k = 0; k < 2 * GT && m_game == G_PLAY; k++) begin
      if (m_time == 1) set_flip(1, 7);
      tick = 1'b1; step(); step();
    end
    check("over_flag", 32'(game_over), 32'd1);
    check("over_time", 32'(time_left), 32'd0);
    check("over_show", 32'(show), 32'd0);
    check("last_flip_scored", 32'(score), 32'd996);
    set_flip(0, 4); step();
    check("frozen_score", 32'(score), 32'd996);
    tick = 1'b1; start = 1'b1; step();
    check("restart_time", 32'(time_left), 32'(GT));
    check("restart_score", 32'(score), 32'd0);

    // Reset mid-round
    for (int i = 0; i < NS; i++) set_flip(i, 4);
    step();
    check("score_20", 32'(score), 32'd20);
    resetn = 1'b0; step();
    check("midreset_score", 32'(score), 32'd0);
    check("midreset_playing", 32'(playing), 32'd0);
    resetn = 1'b1;

    // Randomized play with a bench-side steak emulation
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 599) != 0);
      start  = (m_game == G_PLAY) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 7) == 0);
      tick   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NS; i++) begin
        if (!slot_busy[i] && m_st[i] == ST_SHOW && $urandom_range(0, 1) == 1) slot_busy[i] = 1'b1;
        else if (slot_busy[i] && $urandom_range(0, 7) == 0) slot_busy[i] = 1'b0;
        flip_evt[i] = slot_busy[i] && ($urandom_range(0, 3) == 0);
        flip_level[3*i +: 3] = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
